// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator.
// A pixel-clock divider drives x/y position counters. Every decoded output
// is registered from the next-state position, so it changes in the same
// clock as the counters and cannot glitch. A look-ahead fetch position lets
// a renderer with read latency prefetch pixel data.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 2,
  parameter int PREFETCH = 2,
  parameter int CW       = 10,
  parameter int FW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic          hs,
  output logic          vs,
  output logic [CW-1:0] x_ptr,
  output logic [CW-1:0] y_ptr,
  output logic          valid,
  output logic          pix_tick,
  output logic          line_end,
  output logic          frame_end,
  output logic [FW-1:0] frame_cnt,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          fetch_valid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW1     = CW + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  // Position arithmetic is done one bit wider than the counters so that
  // x + PREFETCH cannot overflow before the modulo.
  localparam logic [CW:0] L_HT       = CW1'(H_TOTAL);
  localparam logic [CW:0] L_HT_LAST  = CW1'(H_TOTAL - 1);
  localparam logic [CW:0] L_VT_LAST  = CW1'(V_TOTAL - 1);
  localparam logic [CW:0] L_HA       = CW1'(H_ACTIVE);
  localparam logic [CW:0] L_VA       = CW1'(V_ACTIVE);
  localparam logic [CW:0] L_HS_BEG   = CW1'(H_ACTIVE + H_FP);
  localparam logic [CW:0] L_HS_END   = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] L_VS_BEG   = CW1'(V_ACTIVE + V_FP);
  localparam logic [CW:0] L_VS_END   = CW1'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0] L_PF       = CW1'(PREFETCH);

  localparam logic HS_ON = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ON = (VS_POL != 0) ? 1'b1 : 1'b0;

  function automatic logic f_active(input logic [CW:0] x, input logic [CW:0] y);
    return (x < L_HA) && (y < L_VA);
  endfunction

  function automatic logic f_hs_level(input logic [CW:0] x);
    return ((x >= L_HS_BEG) && (x < L_HS_END)) ? HS_ON : ~HS_ON;
  endfunction

  function automatic logic f_vs_level(input logic [CW:0] y);
    return ((y >= L_VS_BEG) && (y < L_VS_END)) ? VS_ON : ~VS_ON;
  endfunction

  logic [DW-1:0] r_div;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic [FW-1:0] r_frame_cnt;

  logic          r_hs;
  logic          r_vs;
  logic          r_valid;
  logic          r_pix_tick;
  logic          r_line_end;
  logic          r_frame_end;
  logic [CW-1:0] r_fetch_x;
  logic [CW-1:0] r_fetch_y;
  logic          r_fetch_valid;

  logic          w_tick;
  logic          w_x_last;
  logic          w_y_last;
  logic [DW-1:0] w_div_adv;
  logic [CW-1:0] w_x_adv;
  logic [CW-1:0] w_y_adv;
  logic [FW-1:0] w_frame_cnt_adv;

  logic [DW-1:0] w_div_nxt;
  logic [CW-1:0] w_x_nxt;
  logic [CW-1:0] w_y_nxt;
  logic [CW:0]   w_xn;
  logic [CW:0]   w_yn;
  logic          w_tick_nxt;
  logic [CW:0]   w_fsum;
  logic          w_fwrap;
  logic [CW:0]   w_fx;
  logic [CW:0]   w_fy;

  // Advance the divider and, on the last clock of a pixel, the x/y/frame counters
  always_comb begin
    w_tick          = (r_div == DIV_LAST);
    w_x_last        = ({1'b0, r_x} == L_HT_LAST);
    w_y_last        = ({1'b0, r_y} == L_VT_LAST);
    w_div_adv       = r_div + DW'(1);
    w_x_adv         = r_x;
    w_y_adv         = r_y;
    w_frame_cnt_adv = r_frame_cnt;
    if (w_tick) begin
      w_div_adv = '0;
      w_x_adv   = w_x_last ? '0 : r_x + CW'(1);
      if (w_x_last) begin
        w_y_adv = w_y_last ? '0 : r_y + CW'(1);
        if (w_y_last) begin
          w_frame_cnt_adv = r_frame_cnt + FW'(1);
        end
      end
    end
  end

  // Next-state position (reset forces the origin) and its look-ahead fetch position
  always_comb begin
    w_div_nxt  = reset ? '0 : w_div_adv;
    w_x_nxt    = reset ? '0 : w_x_adv;
    w_y_nxt    = reset ? '0 : w_y_adv;
    w_xn       = {1'b0, w_x_nxt};
    w_yn       = {1'b0, w_y_nxt};
    w_tick_nxt = (w_div_nxt == DIV_LAST);
    w_fsum     = w_xn + L_PF;
    w_fwrap    = (w_fsum >= L_HT);
    w_fx       = w_fwrap ? (w_fsum - L_HT) : w_fsum;
    w_fy       = w_yn;
    if (w_fwrap) begin
      w_fy = (w_yn == L_VT_LAST) ? '0 : w_yn + CW1'(1);
    end
  end

  // Counter state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_div       <= w_div_adv;
      r_x         <= w_x_adv;
      r_y         <= w_y_adv;
      r_frame_cnt <= w_frame_cnt_adv;
    end
  end

  // Registered decodes of the next-state position, aligned with the counters
  always_ff @(posedge clk) begin
    r_pix_tick    <= w_tick_nxt;
    r_line_end    <= w_tick_nxt && (w_xn == L_HT_LAST);
    r_frame_end   <= w_tick_nxt && (w_xn == L_HT_LAST) && (w_yn == L_VT_LAST);
    r_valid       <= f_active(w_xn, w_yn);
    r_hs          <= f_hs_level(w_xn);
    r_vs          <= f_vs_level(w_yn);
    r_fetch_x     <= w_fx[CW-1:0];
    r_fetch_y     <= w_fy[CW-1:0];
    r_fetch_valid <= f_active(w_fx, w_fy);
  end

  assign x_ptr       = r_x;
  assign y_ptr       = r_y;
  assign frame_cnt   = r_frame_cnt;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign valid       = r_valid;
  assign pix_tick    = r_pix_tick;
  assign line_end    = r_line_end;
  assign frame_end   = r_frame_end;
  assign fetch_x     = r_fetch_x;
  assign fetch_y     = r_fetch_y;
  assign fetch_valid = r_fetch_valid;

endmodule
